// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// The master modport is the controller side and the slave modport is the datapath side.
interface multicycle_ctrl_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         op;
  logic               zero;
  logic               mem_ready;
  logic               mem_req;
  logic               MemWrite;
  logic               AdrSrc;
  logic               IRWrite;
  logic               PCWrite;
  logic               RegWrite;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         ImmSrc;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op, state_o
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM that sequences a multicycle RV32I datapath with a ready-based memory handshake.
// Define CTRL_PERF_CNT_EN to add the cycle_cnt and instret_cnt performance counters.
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instret_cnt
`endif
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    EXECI    = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BEQ      = STATE_W'(9),
    JAL      = STATE_W'(10),
    ERROR    = STATE_W'(15)
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:    if (bus.mem_ready) w_next = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_R:         w_next = EXECR;
          OP_I:         w_next = EXECI;
          OP_BEQ:       w_next = BEQ;
          OP_JAL:       w_next = JAL;
          default:      w_next = ERROR;
        endcase
      end
      MEMADR:   w_next = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (bus.mem_ready) w_next = MEMWB;
      MEMWB:    w_next = FETCH;
      MEMWRITE: if (bus.mem_ready) w_next = FETCH;
      EXECR:    w_next = ALUWB;
      EXECI:    w_next = ALUWB;
      ALUWB:    w_next = FETCH;
      BEQ:      w_next = FETCH;
      JAL:      w_next = ALUWB;
      ERROR:    w_next = ERROR;
      default:  w_next = ERROR;
    endcase
  end

  // Outputs follow the state only; while rst_n is low everything is held at 0 so a
  // reset in the middle of an access cannot leak a write enable.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUOp      = 2'b00;
    bus.ImmSrc     = 2'b00;
    bus.illegal_op = 1'b0;
    if (rst_n) begin
      case (bus.op)
        OP_SW:   bus.ImmSrc = 2'b01;
        OP_BEQ:  bus.ImmSrc = 2'b10;
        OP_JAL:  bus.ImmSrc = 2'b11;
        default: bus.ImmSrc = 2'b00;
      endcase
      case (r_state)
        FETCH: begin
          bus.mem_req   = 1'b1;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
          bus.IRWrite   = bus.mem_ready;
          bus.PCWrite   = bus.mem_ready;
        end
        DECODE: begin
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b01;
        end
        MEMADR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
        end
        MEMREAD: begin
          bus.mem_req = 1'b1;
          bus.AdrSrc  = 1'b1;
        end
        MEMWB: begin
          bus.ResultSrc = 2'b01;
          bus.RegWrite  = 1'b1;
        end
        MEMWRITE: begin
          bus.mem_req  = 1'b1;
          bus.AdrSrc   = 1'b1;
          bus.MemWrite = 1'b1;
        end
        EXECR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUOp   = 2'b10;
        end
        EXECI: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
          bus.ALUOp   = 2'b10;
        end
        ALUWB:    bus.RegWrite = 1'b1;
        BEQ: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUOp   = 2'b01;
          bus.PCWrite = bus.zero;
        end
        JAL: begin
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b10;
          bus.PCWrite = 1'b1;
        end
        ERROR:    bus.illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.state_o = r_state;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;
  logic        w_retire;

  // An instruction retires on the step that returns the FSM to FETCH.
  assign w_retire = (w_next == FETCH) &&
                    ((r_state == MEMWB) || (r_state == MEMWRITE) ||
                     (r_state == ALUWB) || (r_state == BEQ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= 32'd0;
      r_instret_cnt <= 32'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_retire) r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, scoreboard-driven bench for multicycle_ctrl: each step queues the expected
// Moore outputs for the current state and compares them half a cycle later.
module tb_multicycle_ctrl;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.STATE_W(4)) bus ();

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ins_cnt;
  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cycle_cnt(cyc_cnt), .instret_cnt(ins_cnt)
  );
`else
  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`endif

  logic [20:0] sb_q[$];
  int n_run = 0;
  int n_fail = 0;

  // {state, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op}
  function automatic logic [20:0] ev(input logic [3:0] st, input logic mr, input logic mw,
                                     input logic as, input logic ir, input logic pw,
                                     input logic rw, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sbv, input logic [1:0] ao,
                                     input logic [1:0] im, input logic il);
    return {st, mr, mw, as, ir, pw, rw, rs, sa, sbv, ao, im, il};
  endfunction

  function automatic logic [20:0] e_fetch(input logic [1:0] im, input logic r);
    return ev(4'd0, 1'b1, 1'b0, 1'b0, r, r, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, im, 1'b0);
  endfunction
  function automatic logic [20:0] e_dec(input logic [1:0] im);
    return ev(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, im, 1'b0);
  endfunction
  function automatic logic [20:0] e_madr(input logic [1:0] im);
    return ev(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, im, 1'b0);
  endfunction
  function automatic logic [20:0] e_mrd(input logic [1:0] im);
    return ev(4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b0);
  endfunction
  function automatic logic [20:0] e_mwb(input logic [1:0] im);
    return ev(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, im, 1'b0);
  endfunction
  function automatic logic [20:0] e_mwr(input logic [1:0] im);
    return ev(4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b0);
  endfunction
  function automatic logic [20:0] e_exr(input logic [1:0] im);
    return ev(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, im, 1'b0);
  endfunction
  function automatic logic [20:0] e_exi(input logic [1:0] im);
    return ev(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, im, 1'b0);
  endfunction
  function automatic logic [20:0] e_awb(input logic [1:0] im);
    return ev(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b0);
  endfunction
  function automatic logic [20:0] e_beq(input logic [1:0] im, input logic z);
    return ev(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, z, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, im, 1'b0);
  endfunction
  function automatic logic [20:0] e_jal(input logic [1:0] im);
    return ev(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, im, 1'b0);
  endfunction
  function automatic logic [20:0] e_err();
    return ev(4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
  endfunction

  function automatic logic [20:0] observed();
    return {bus.state_o, bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite,
            bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc,
            bus.illegal_op};
  endfunction

  task automatic compare(input string tag);
    logic [20:0] e;
    logic [20:0] a;
    e = sb_q.pop_front();
    a = observed();
    n_run++;
    assert (a === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, a, e);
    end
  endtask

  task automatic step(input string tag, input logic [6:0] op, input logic z,
                      input logic rdy, input logic [20:0] e);
    @(negedge clk);
    bus.op = op;
    bus.zero = z;
    bus.mem_ready = rdy;
    sb_q.push_back(e);
    #1;
    compare(tag);
  endtask

  initial begin
    bus.op = LW;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;

    step("reset", LW, 1'b0, 1'b0, 21'd0);
    #2 rst_n = 1'b1;

    step("lw_fetch", LW, 1'b0, 1'b1, e_fetch(2'b00, 1'b1));
    step("lw_dec",   LW, 1'b0, 1'b1, e_dec(2'b00));
    step("lw_adr",   LW, 1'b0, 1'b1, e_madr(2'b00));
    step("lw_read",  LW, 1'b0, 1'b1, e_mrd(2'b00));
    step("lw_wb",    LW, 1'b0, 1'b1, e_mwb(2'b00));

    step("sw_fetch_wait", SW, 1'b0, 1'b0, e_fetch(2'b01, 1'b0));
    step("sw_fetch",      SW, 1'b0, 1'b1, e_fetch(2'b01, 1'b1));
    step("sw_dec",        SW, 1'b0, 1'b1, e_dec(2'b01));
    step("sw_adr",        SW, 1'b0, 1'b1, e_madr(2'b01));
    for (int i = 0; i < 3; i++) step("sw_write_wait", SW, 1'b0, 1'b0, e_mwr(2'b01));
    step("sw_write",      SW, 1'b0, 1'b1, e_mwr(2'b01));

    step("beq1_fetch", BQ, 1'b1, 1'b1, e_fetch(2'b10, 1'b1));
    step("beq1_dec",   BQ, 1'b1, 1'b1, e_dec(2'b10));
    step("beq1_taken", BQ, 1'b1, 1'b1, e_beq(2'b10, 1'b1));
    step("beq0_fetch", BQ, 1'b0, 1'b1, e_fetch(2'b10, 1'b1));
    step("beq0_dec",   BQ, 1'b0, 1'b1, e_dec(2'b10));
    step("beq0_not",   BQ, 1'b0, 1'b1, e_beq(2'b10, 1'b0));

    step("jal_fetch", JL, 1'b0, 1'b1, e_fetch(2'b11, 1'b1));
    step("jal_dec",   JL, 1'b0, 1'b1, e_dec(2'b11));
    step("jal_jump",  JL, 1'b0, 1'b1, e_jal(2'b11));
    step("jal_link",  JL, 1'b0, 1'b1, e_awb(2'b11));

    step("r_fetch", RT, 1'b0, 1'b1, e_fetch(2'b00, 1'b1));
    step("r_dec",   RT, 1'b0, 1'b1, e_dec(2'b00));
    step("r_exec",  RT, 1'b0, 1'b1, e_exr(2'b00));
    step("r_wb",    RT, 1'b0, 1'b1, e_awb(2'b00));

    step("i_fetch", IT, 1'b0, 1'b1, e_fetch(2'b00, 1'b1));
    step("i_dec",   IT, 1'b0, 1'b1, e_dec(2'b00));
    step("i_exec",  IT, 1'b0, 1'b1, e_exi(2'b00));
    step("i_wb",    IT, 1'b0, 1'b1, e_awb(2'b00));

    step("bad_fetch", BAD, 1'b0, 1'b1, e_fetch(2'b00, 1'b1));
    step("bad_dec",   BAD, 1'b0, 1'b1, e_dec(2'b00));
    for (int i = 0; i < 20; i++)
      step("err_hold", BAD, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e_err());

    @(negedge clk);
    rst_n = 1'b0;
    sb_q.push_back(21'd0);
    #1 compare("err_reset");
    #2;
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;

    step("post_err_fetch", LW, 1'b0, 1'b1, e_fetch(2'b00, 1'b1));
    step("stall_dec",      LW, 1'b0, 1'b1, e_dec(2'b00));
    step("stall_adr",      LW, 1'b0, 1'b1, e_madr(2'b00));
    step("stall_read0",    LW, 1'b0, 1'b0, e_mrd(2'b00));
    step("stall_read1",    LW, 1'b0, 1'b0, e_mrd(2'b00));
    #2 rst_n = 1'b0;
    sb_q.push_back(21'd0);
    #1 compare("rst_midread");
    @(posedge clk);
    sb_q.push_back(21'd0);
    #1 compare("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    step("rst_fetch", LW, 1'b0, 1'b1, e_fetch(2'b00, 1'b1));
    step("rst_dec",   LW, 1'b0, 1'b1, e_dec(2'b00));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a multicycle RV32I datapath: fetch, decode, execute, memory and writeback steps.
- Drives the immediate-select code into the immediate generator, plus all datapath mux selects and write enables.
- Handles a simple ready-based memory handshake.
- Sits beside the datapath in the processor top and takes the opcode from the instruction register.

Parameters:
- STATE_W, 4, width of the state register and of the debug state output.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op  input  7  opcode field (instr[6:0]) from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current access this cycle.
- mem_req  output  1  memory access request.
- MemWrite  output  1  store enable.
- AdrSrc  output  1  memory address: 0=PC, 1=ALU result register.
- IRWrite  output  1  load instruction register.
- PCWrite  output  1  load PC.
- RegWrite  output  1  register file write.
- ResultSrc  output  2  00=ALUOut, 01=mem data, 10=ALU result.
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1.
- ALUSrcB  output  2  00=rs2, 01=immediate, 10=constant 4.
- ALUOp  output  2  00=add, 01=subtract/compare, 10=funct-decoded.
- ImmSrc  output  2  00=I, 01=S, 10=B, 11=J.
- illegal_op  output  1  sticky unsupported-opcode flag.
- state_o  output  STATE_W  current state, for debug.

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, ERROR=15
- Reset:
  - rst_n low sets the state to FETCH immediately and clears illegal_op.
  - While rst_n=0, all enables (mem_req, MemWrite, IRWrite, PCWrite, RegWrite) are forced 0 and all selects are 0.
  - Reset mid-access abandons the access; no write enable is asserted in the reset cycle.
- Unlisted outputs are 0 in every state.
- FETCH:
  - mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> ERROR
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then goes to FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1. Holds until mem_ready=1, then goes to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero, then goes to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then goes to ALUWB (link write).
- ERROR: illegal_op=1, all enables 0. Held until reset; mem_ready and op are ignored.
- ImmSrc is combinational from op in all states:
  - lw or I-ALU -> 00
  - sw -> 01
  - beq -> 10
  - jal -> 11
  - other -> 00
- Instruction latency with zero-wait memory (mem_ready=1 on first request):
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type, I-ALU, jal: 4 cycles
  - beq: 3 cycles
- Each wait cycle (mem_ready=0 while requesting) adds exactly one cycle, with outputs held stable.
- mem_ready outside a requesting state is ignored.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - cycle_cnt[31:0]: increments every clock when rst_n=1.
  - instret_cnt[31:0]: increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
- Both counters wrap from 0xFFFFFFFF to 0 and are cleared by rst_n.
- When not defined, neither the ports nor the logic exist; all other behaviour is identical.

Test Plan:
- lw (op=0000011) with mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 only in cycle 5 with ResultSrc=01; ImmSrc=00 throughout.
- sw (op=0100011) with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, AdrSrc=1, ImmSrc=01; back in FETCH after 7 cycles total.
- beq (op=1100011), first with zero=1 then with zero=0 -> PCWrite=1 in BEQ cycle, then PCWrite=0; ImmSrc=10; 3 cycles each.
- jal (op=1101111) -> JAL state has PCWrite=1 and ImmSrc=11; next ALUWB has RegWrite=1; back in FETCH after 4 cycles.
- op=1111111 decoded -> ERROR (state_o=15), illegal_op=1, no enables for 20 cycles; rst_n pulse -> FETCH, illegal_op=0.
- rst_n asserted during MEMREAD stall -> state_o=0 immediately, all enables 0; after release, FETCH with mem_ready=1 gives IRWrite=PCWrite=1.
